// File: rtl/handshake_packer_pkg.sv
// handshake_packer_pkg: shared sizing and keep-mask helpers for the packer
package handshake_packer_pkg;

    localparam int KEEP_MAX = 256;

    function automatic int lane_bits(input int count);
        return (count > 2) ? $clog2(count) : 1;
    endfunction

    function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned lane);
        return (KEEP_MAX'(2) << lane) - KEEP_MAX'(1);
    endfunction

endpackage

// File: rtl/handshake_packer.sv
// handshake_packer: packs PACK_COUNT narrow values into one registered wide word
module handshake_packer
    import handshake_packer_pkg::*;
#(
    parameter int VALUE_BITS = 8,
    parameter int PACK_COUNT = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [VALUE_BITS-1:0]            i_value,
    input  logic                             i_last,
    input  logic                             i_valid,
    output logic                             o_ready,
    output logic [VALUE_BITS*PACK_COUNT-1:0] o_value,
    output logic [PACK_COUNT-1:0]            o_keep,
    output logic                             o_last,
    output logic                             o_valid,
    input  logic                             i_ready
);

    localparam int LW = lane_bits(PACK_COUNT);
    localparam int WW = VALUE_BITS * PACK_COUNT;

    logic [LW-1:0] r_lane;
    logic [WW-1:0] r_acc;
    logic          w_accept;
    logic          w_complete;
    logic [WW-1:0] w_word;

    assign o_ready    = ~o_valid | i_ready;
    assign w_accept   = i_valid & o_ready;
    assign w_complete = w_accept & ((r_lane == LW'(PACK_COUNT - 1)) | i_last);

    // Completed word: stored lanes below the current lane, new value in it, zeros above
    always_comb begin
        w_word = '0;
        for (int k = 0; k < PACK_COUNT; k++) begin
            if (k < int'(r_lane))
                w_word[k*VALUE_BITS +: VALUE_BITS] = r_acc[k*VALUE_BITS +: VALUE_BITS];
            else if (k == int'(r_lane))
                w_word[k*VALUE_BITS +: VALUE_BITS] = i_value;
        end
    end

    // Accumulator and lane counter advance only on accepted values
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lane <= '0;
            r_acc  <= '0;
        end else if (w_complete) begin
            r_lane <= '0;
            r_acc  <= '0;
        end else if (w_accept) begin
            r_acc[r_lane*VALUE_BITS +: VALUE_BITS] <= i_value;
            r_lane <= r_lane + LW'(1);
        end
    end

    // Output register loads on a completing beat and drains on transfer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            o_value <= '0;
            o_keep  <= '0;
            o_last  <= 1'b0;
            o_valid <= 1'b0;
        end else if (w_complete) begin
            o_value <= w_word;
            o_keep  <= PACK_COUNT'(keep_mask(int'(r_lane)));
            o_last  <= i_last;
            o_valid <= 1'b1;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_handshake_packer.sv
// tb_handshake_packer: directed plus random checks against a queue-based packing model
module tb_handshake_packer;

    localparam int VB = 8;
    localparam int PC = 4;
    localparam int WW = VB * PC;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [VB-1:0] i_value = '0;
    logic          i_last = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic          o_ready;
    logic [WW-1:0] o_value;
    logic [PC-1:0] o_keep;
    logic          o_last;
    logic          o_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [VB-1:0] part[$];
    logic [WW-1:0] m_word = '0;
    logic [PC-1:0] m_keep = '0;
    logic          m_last = 1'b0;
    logic          m_valid = 1'b0;

    handshake_packer #(.VALUE_BITS(VB), .PACK_COUNT(PC)) dut (
        .clock(clock), .reset_n(reset_n), .i_value(i_value), .i_last(i_last),
        .i_valid(i_valid), .o_ready(o_ready), .o_value(o_value), .o_keep(o_keep),
        .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        part.delete();
        m_word = '0;
        m_keep = '0;
        m_last = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_valid"}, 64'(o_valid), 64'(m_valid));
        chk({tag, "_value"}, 64'(o_value), 64'(m_word));
        chk({tag, "_keep"}, 64'(o_keep), 64'(m_keep));
        chk({tag, "_last"}, 64'(o_last), 64'(m_last));
    endtask

    // One clock: drive at negedge, check ready, update model at posedge, check outputs next negedge
    task automatic cyc(input logic v, input logic [VB-1:0] d, input logic l, input logic r);
        logic mr, ma;
        i_valid = v;
        i_value = d;
        i_last = l;
        i_ready = r;
        #1;
        mr = !m_valid || r;
        ma = v && mr;
        chk("ready", 64'(o_ready), 64'(mr));
        @(posedge clock);
        if (ma) begin
            part.push_back(d);
            if (part.size() == PC || l) begin
                m_word = '0;
                foreach (part[k]) m_word[k*VB +: VB] = part[k];
                m_keep = PC'((1 << part.size()) - 1);
                m_last = l;
                m_valid = 1'b1;
                part.delete();
            end else if (mr) begin
                m_valid = 1'b0;
            end
        end else if (mr) begin
            m_valid = 1'b0;
        end
        @(negedge clock);
        chk_outputs("out");
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        chk_outputs("reset");
        reset_n = 1'b1;

        // Full word, no last
        cyc(1, 8'h11, 0, 1);
        cyc(1, 8'h22, 0, 1);
        cyc(1, 8'h33, 0, 1);
        cyc(1, 8'h44, 0, 1);
        chk("t1_word", 64'(o_value), 64'h44332211);
        chk("t1_keep", 64'(o_keep), 64'hF);
        chk("t1_last", 64'(o_last), 64'h0);

        // Short packet closed by i_last, then next value in lane 0
        cyc(1, 8'hA1, 0, 1);
        cyc(1, 8'hA2, 1, 1);
        chk("t2_word", 64'(o_value), 64'h0000A2A1);
        chk("t2_keep", 64'(o_keep), 64'h3);
        chk("t2_last", 64'(o_last), 64'h1);
        cyc(1, 8'h55, 1, 1);
        chk("t2_next_lane0", 64'(o_value), 64'h00000055);

        // Single-value packet
        cyc(1, 8'h7E, 1, 1);
        chk("t3_word", 64'(o_value), 64'h0000007E);
        chk("t3_keep", 64'(o_keep), 64'h1);
        chk("t3_last", 64'(o_last), 64'h1);

        // Backpressure with a full output register
        for (int i = 1; i <= 4; i++) cyc(1, VB'(i), 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 8'h05, 0, 0);
            chk("bp_ready", 64'(o_ready), 64'h0);
            chk("bp_hold", 64'(o_value), 64'h04030201);
        end
        for (int i = 5; i <= 8; i++) cyc(1, VB'(i), 0, 1);
        chk("bp_word2", 64'(o_value), 64'h08070605);
        cyc(0, 8'h00, 0, 1);

        // Streaming three words back to back
        for (int i = 0; i < 12; i++) begin
            cyc(1, VB'(i), 0, 1);
            if (i % 4 == 3)
                chk("stream_word", 64'(o_value), 64'({VB'(i), VB'(i - 1), VB'(i - 2), VB'(i - 3)}));
        end
        cyc(0, 8'h00, 0, 1);

        // Asynchronous reset in the middle of a word
        cyc(1, 8'hC1, 0, 1);
        cyc(1, 8'hC2, 0, 1);
        i_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk_outputs("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        cyc(1, 8'hD1, 0, 1);
        cyc(1, 8'hD2, 0, 1);
        cyc(1, 8'hD3, 0, 1);
        cyc(1, 8'hD4, 0, 1);
        chk("rst_word", 64'(o_value), 64'hD4D3D2D1);
        chk("rst_keep", 64'(o_keep), 64'hF);

        // Random traffic against the model
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, VB'($urandom), $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) < 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
